// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared constants for the quadratic evaluator datapath
package poly_pkg;

  localparam int W_DEFAULT = 8;

  localparam logic [1:0] M0_ZERO = 2'b00;
  localparam logic [1:0] M0_A    = 2'b01;
  localparam logic [1:0] M0_B    = 2'b10;
  localparam logic [1:0] M0_C    = 2'b11;

  localparam logic [1:0] M1_M0   = 2'b00;
  localparam logic [1:0] M1_X    = 2'b01;
  localparam logic [1:0] M1_S    = 2'b10;
  localparam logic [1:0] M1_H    = 2'b11;

  localparam logic [1:0] M2_X    = 2'b00;
  localparam logic [1:0] M2_H    = 2'b01;
  localparam logic [1:0] M2_S    = 2'b10;
  localparam logic [1:0] M2_ZERO = 2'b11;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/poly_datapath_if.sv
// rtl/poly_datapath_if.sv - controller strobes, operands and result handshake
interface poly_datapath_if import poly_pkg::*; #(parameter int W = W_DEFAULT);

  logic [W-1:0] x_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] c_in;
  logic         H;
  logic         load_x;
  logic         load_s;
  logic         load_h;
  logic [1:0]   sel_m0;
  logic [1:0]   sel_m1;
  logic [1:0]   sel_m2;
  logic         done;
  logic [W-1:0] result;
  logic         result_ovf;
  logic         result_valid;
  logic         result_ready;
  logic         overrun;

  modport master (
    output x_in, a_in, b_in, c_in, H, load_x, load_s, load_h,
           sel_m0, sel_m1, sel_m2, done, result_ready,
    input  result, result_ovf, result_valid, overrun
  );

  modport slave (
    input  x_in, a_in, b_in, c_in, H, load_x, load_s, load_h,
           sel_m0, sel_m1, sel_m2, done, result_ready,
    output result, result_ovf, result_valid, overrun
  );

endinterface

// File: rtl/poly_alu.sv
// rtl/poly_alu.sv - unsigned add/multiply with overflow out of W bits
module poly_alu import poly_pkg::*; #(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] i_p,
  input  logic [W-1:0] i_q,
  input  logic         i_h,
  output logic [W-1:0] o_result,
  output logic         o_ovf
);

  logic [2*W-1:0] w_p_ext;
  logic [2*W-1:0] w_q_ext;
  logic [2*W-1:0] w_full;

  assign w_p_ext = {{W{1'b0}}, i_p};
  assign w_q_ext = {{W{1'b0}}, i_q};

  // Both ops evaluated at 2W so the upper half is the overflow indicator.
  assign w_full   = (i_h == OP_MUL) ? (w_p_ext * w_q_ext) : (w_p_ext + w_q_ext);
  assign o_result = w_full[W-1:0];
  assign o_ovf    = |w_full[2*W-1:W];

endmodule

// File: rtl/poly_datapath.sv
// rtl/poly_datapath.sv - operand/accumulator registers, muxes, ALU and result capture
module poly_datapath import poly_pkg::*; #(
  parameter int W = W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  poly_datapath_if.slave   bus
);

  logic [W-1:0] r_x, r_a, r_b, r_c, r_s, r_h;
  logic         r_ovf_acc;
  logic [W-1:0] r_result;
  logic         r_result_ovf;
  logic         r_result_valid;
  logic         r_overrun;

  logic [W-1:0] w_m0, w_p, w_q, w_alu;
  logic         w_alu_ovf;

  always_comb begin
    w_m0 = '0;
    case (bus.sel_m0)
      M0_A:    w_m0 = r_a;
      M0_B:    w_m0 = r_b;
      M0_C:    w_m0 = r_c;
      default: w_m0 = '0;
    endcase
  end

  always_comb begin
    w_p = '0;
    case (bus.sel_m1)
      M1_X:    w_p = r_x;
      M1_S:    w_p = r_s;
      M1_H:    w_p = r_h;
      default: w_p = w_m0;
    endcase
  end

  always_comb begin
    w_q = '0;
    case (bus.sel_m2)
      M2_X:    w_q = r_x;
      M2_H:    w_q = r_h;
      M2_S:    w_q = r_s;
      default: w_q = '0;
    endcase
  end

  poly_alu #(.W(W)) u_alu (
    .i_p      (w_p),
    .i_q      (w_q),
    .i_h      (bus.H),
    .o_result (w_alu),
    .o_ovf    (w_alu_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x            <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_c            <= '0;
      r_s            <= '0;
      r_h            <= '0;
      r_ovf_acc      <= 1'b0;
      r_result       <= '0;
      r_result_ovf   <= 1'b0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (bus.load_x) begin
        r_x <= bus.x_in;
        r_a <= bus.a_in;
        r_b <= bus.b_in;
        r_c <= bus.c_in;
      end
      if (bus.load_s) r_s <= w_alu;
      if (bus.load_h) r_h <= w_alu;

      // A new evaluation starts clean; overflow from the overlapping step belongs to the old one.
      if (bus.load_x)
        r_ovf_acc <= 1'b0;
      else if (w_alu_ovf && (bus.load_s || bus.load_h))
        r_ovf_acc <= 1'b1;

      // Capture uses pre-edge reg_s/ovf_acc since the done cycle also rewrites reg_s.
      if (bus.done) begin
        r_result       <= r_s;
        r_result_ovf   <= r_ovf_acc;
        r_result_valid <= 1'b1;
        if (r_result_valid && !bus.result_ready) r_overrun <= 1'b1;
      end else if (r_result_valid && bus.result_ready) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign bus.result       = r_result;
  assign bus.result_ovf   = r_result_ovf;
  assign bus.result_valid = r_result_valid;
  assign bus.overrun      = r_overrun;

endmodule
